// File: rtl/clock_sm.sv
// clock_sm: clock view/set mode FSM; define CLOCK_SM_TIMEOUT_EN for an idle timeout back to HHMM
module clock_sm #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_short,
  input  logic       key_long,
  output logic       HHMM_view,
  output logic       MMSS_view,
  output logic       S_H1,
  output logic       S_H2,
  output logic       S_M1,
  output logic       S_M2,
  output logic       S_S1,
  output logic       S_S2,
  output logic [2:0] state
);
  typedef enum logic [2:0] {
    HHMM   = 3'd0,
    MMSS   = 3'd1,
    SET_H1 = 3'd2,
    SET_H2 = 3'd3,
    SET_M1 = 3'd4,
    SET_M2 = 3'd5,
    SET_S1 = 3'd6,
    SET_S2 = 3'd7
  } state_t;
  state_t state_q, state_d, key_nxt;
  logic   key;
  assign key = key_long | key_short;
  always_comb begin
    key_nxt = state_q;
    if (key_long)
      key_nxt = (state_q == HHMM || state_q == MMSS) ? SET_H1 : HHMM;
    else if (key_short)
      key_nxt = (state_q == MMSS || state_q == SET_S2) ? HHMM : state_t'(state_q + 3'd1);
  end
`ifdef CLOCK_SM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          expire;
  always_comb begin
    expire  = !key && state_q != HHMM && cnt_q == CW'(TIMEOUT_CYCLES - 1);
    cnt_d   = (key || state_q == HHMM || expire) ? '0 : cnt_q + 1'b1;
    state_d = expire ? HHMM : key_nxt;
  end
  always_ff @(posedge clk)
    cnt_q <= !rst_n ? '0 : cnt_d;
`else
  assign state_d = key_nxt;
`endif
  always_ff @(posedge clk)
    state_q <= !rst_n ? HHMM : state_d;
  assign state     = state_q;
  assign HHMM_view = state_q == HHMM;
  assign MMSS_view = state_q == MMSS;
  assign S_H1      = state_q == SET_H1;
  assign S_H2      = state_q == SET_H2;
  assign S_M1      = state_q == SET_M1;
  assign S_M2      = state_q == SET_M2;
  assign S_S1      = state_q == SET_S1;
  assign S_S2      = state_q == SET_S2;
endmodule

// File: tb/tb_clock_sm.sv
// tb_clock_sm: directed self-checking bench for clock_sm
module tb_clock_sm;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_short = 1'b0;
  logic       key_long = 1'b0;
  logic       HHMM_view, MMSS_view, S_H1, S_H2, S_M1, S_M2, S_S1, S_S2;
  logic [2:0] state;
  int         errors = 0;
  int         checks = 0;
  clock_sm #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .key_short(key_short),
    .key_long(key_long),
    .HHMM_view(HHMM_view),
    .MMSS_view(MMSS_view),
    .S_H1(S_H1),
    .S_H2(S_H2),
    .S_M1(S_M1),
    .S_M2(S_M2),
    .S_S1(S_S1),
    .S_S2(S_S2),
    .state(state)
  );
  always #5 clk = ~clk;
  task automatic step(input logic l, input logic s, input logic r);
    rst_n = r;
    key_long = l;
    key_short = s;
    @(posedge clk);
    #1;
    key_long = 1'b0;
    key_short = 1'b0;
    rst_n = 1'b1;
  endtask
  task automatic check(input string tag, input logic [2:0] exp);
    logic [7:0] oh_exp;
    logic [7:0] oh_obs;
    oh_exp = 8'h80 >> exp;
    oh_obs = {HHMM_view, MMSS_view, S_H1, S_H2, S_M1, S_M2, S_S1, S_S2};
    checks++;
    assert (state === exp) else begin
      errors++;
      $error("FAIL %s state: got %0d want %0d", tag, state, exp);
    end
    checks++;
    assert (oh_obs === oh_exp) else begin
      errors++;
      $error("FAIL %s outputs: got %b want %b", tag, oh_obs, oh_exp);
    end
  endtask
  initial begin
    step(0, 0, 0); check("reset", 3'd0);
    step(1, 1, 0); check("reset_keys_high", 3'd0);
    step(1, 0, 1); check("long_0_to_2", 3'd2);
    step(0, 1, 1); check("short_2_to_3", 3'd3);
    step(0, 1, 1); check("short_3_to_4", 3'd4);
    step(0, 1, 1); check("short_4_to_5", 3'd5);
    step(0, 1, 1); check("short_5_to_6", 3'd6);
    step(0, 1, 1); check("short_6_to_7", 3'd7);
    step(0, 1, 1); check("short_7_to_0", 3'd0);
    step(0, 1, 1); check("short_0_to_1", 3'd1);
    step(0, 1, 1); check("short_1_to_0", 3'd0);
    step(0, 0, 1); check("idle_hold_0", 3'd0);
    step(0, 1, 1); check("short_0_to_1b", 3'd1);
    step(0, 0, 1); check("idle_hold_1", 3'd1);
    step(1, 0, 1); check("long_1_to_2", 3'd2);
    step(1, 0, 1); check("long_2_abort", 3'd0);
    step(1, 0, 1); check("long_0_to_2b", 3'd2);
    step(0, 1, 1); check("short_2_to_3b", 3'd3);
    step(0, 1, 1); check("short_3_to_4b", 3'd4);
    step(1, 0, 1); check("long_4_abort", 3'd0);
    step(1, 1, 1); check("both_priority_long", 3'd2);
    step(0, 1, 1); check("short_2_to_3c", 3'd3);
    step(0, 1, 1); check("short_3_to_4c", 3'd4);
    step(0, 1, 1); check("short_4_to_5c", 3'd5);
    step(1, 1, 1); check("both_in_5_abort", 3'd0);
    step(1, 0, 1); step(0, 1, 1); step(0, 1, 1); step(0, 1, 1);
    check("reach_5", 3'd5);
    step(0, 1, 0); check("reset_in_5", 3'd0);
    step(0, 1, 1); check("held_edge1", 3'd1);
    step(0, 1, 1); check("held_edge2", 3'd0);
    step(0, 1, 1); check("held_edge3", 3'd1);
    step(0, 1, 1); check("held_back_0", 3'd0);
    step(1, 0, 1); step(0, 1, 1); check("enter_3", 3'd3);
`ifdef CLOCK_SM_TIMEOUT_EN
    for (int i = 0; i < 15; i++) step(0, 0, 1);
    check("idle_15_no_timeout", 3'd3);
    step(0, 0, 1); check("idle_16_timeout", 3'd0);
    step(1, 0, 1); step(0, 1, 1); check("enter_3_again", 3'd3);
    for (int i = 0; i < 9; i++) step(0, 0, 1);
    check("idle_9", 3'd3);
    step(0, 1, 1); check("short_at_10_restart", 3'd4);
    for (int i = 0; i < 15; i++) step(0, 0, 1);
    check("restarted_15_no_timeout", 3'd4);
    step(0, 0, 1); check("restarted_16_timeout", 3'd0);
`else
    for (int i = 0; i < 40; i++) step(0, 0, 1);
    check("no_timeout_persist", 3'd3);
    step(1, 0, 1); check("long_3_abort", 3'd0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
